// File: rtl/tuner_cmd_seq.sv
// tuner_cmd_seq: host-side INIT/SEARCH/LOCK bring-up sequencer for the
// tuner PHY, with per-command timeout, bounded retries and UNLOCK on stop.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start_i, stop_i   single-cycle bring-up / unlock requests
//   cmd_o/_valid_o    command to PHY, held until cmd_ready_i
//   cmd_ready_i       PHY accepts command
//   state_i           PHY status (IDLE/ACTIVE/DONE/ERROR)
//   locked_o          bring-up complete
//   error_o           sequencer in FAIL
//   busy_o            issuing or waiting on a command
//   retry_cnt_o       retries consumed in current bring-up
//   seq_state_o       FSM state for debug
//
// Optional: TUNER_SEQ_AUTO_RELOCK_EN makes a PHY ERROR while locked
// re-run bring-up through the retry path instead of going to FAIL.

package tuner_pkg;

  typedef enum logic [4:0] {
    CMD_INIT   = 5'd1,
    CMD_SEARCH = 5'd2,
    CMD_LOCK   = 5'd3,
    CMD_UNLOCK = 5'd4
  } tuner_cmd_e;

  typedef enum logic [4:0] {
    PHY_IDLE   = 5'd0,
    PHY_ACTIVE = 5'd1,
    PHY_DONE   = 5'd2,
    PHY_ERROR  = 5'd3
  } tuner_state_e;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_ISSUE  = 3'd1,
    SEQ_WAIT   = 3'd2,
    SEQ_LOCKED = 3'd3,
    SEQ_FAIL   = 3'd4
  } seq_state_e;

endpackage

module tuner_cmd_seq
  import tuner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         stop_i,
  output tuner_cmd_e   cmd_o,
  output logic         cmd_valid_o,
  input  logic         cmd_ready_i,
  input  tuner_state_e state_i,
  output logic         locked_o,
  output logic         error_o,
  output logic         busy_o,
  output logic [3:0]   retry_cnt_o,
  output logic [2:0]   seq_state_o
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RMAX  = 4'(MAX_RETRY);

  seq_state_e    state_q, state_d;
  tuner_cmd_e    cmd_q, cmd_d;
  logic [3:0]    retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic          pend_q, pend_d;
  logic          valid_q;
  logic          locked_q;
  logic          error_q;
  logic          busy_q;

  logic phy_active;
  logic phy_done;
  logic phy_err;
  logic tmo;
  logic pend;
  logic done_acc;
  logic fail_path;

  assign phy_active = (state_i == PHY_ACTIVE);
  assign phy_done   = (state_i == PHY_DONE);
  assign phy_err    = (state_i == PHY_ERROR);
  assign tmo        = (timer_q == TLAST);

  // A stop arriving on the same cycle as a DONE/failure still
  // redirects to UNLOCK rather than being lost.
  assign pend = pend_q | stop_i;

  // DONE only counts once this command has been seen ACTIVE, so a
  // DONE left over from the previous command is ignored.
  assign done_acc = armed_q & phy_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      cmd_q    <= CMD_INIT;
      retry_q  <= '0;
      timer_q  <= '0;
      armed_q  <= 1'b0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      armed_q  <= armed_d;
      pend_q   <= pend_d;
      valid_q  <= (state_d == SEQ_ISSUE);
      locked_q <= (state_d == SEQ_LOCKED);
      error_q  <= (state_d == SEQ_FAIL);
      busy_q   <= (state_d == SEQ_ISSUE) |
                  (state_d == SEQ_WAIT);
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    armed_d   = armed_q;
    pend_d    = pend_q;
    fail_path = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          retry_d = '0;
          cmd_d   = CMD_INIT;
          state_d = SEQ_ISSUE;
        end
      end

      SEQ_ISSUE: begin
        if (stop_i) pend_d = 1'b1;
        if (cmd_ready_i) begin
          state_d = SEQ_WAIT;
          timer_d = '0;
          armed_d = 1'b0;
        end
      end

      SEQ_WAIT: begin
        if (stop_i) pend_d = 1'b1;
        if (!tmo) timer_d = timer_q + TW'(1);
        if (phy_active) armed_d = 1'b1;
        if (done_acc) begin
          if (cmd_q == CMD_UNLOCK) begin
            state_d = SEQ_IDLE;
          end else if (pend) begin
            cmd_d   = CMD_UNLOCK;
            state_d = SEQ_ISSUE;
          end else if (cmd_q == CMD_INIT) begin
            cmd_d   = CMD_SEARCH;
            state_d = SEQ_ISSUE;
          end else if (cmd_q == CMD_SEARCH) begin
            cmd_d   = CMD_LOCK;
            state_d = SEQ_ISSUE;
          end else begin
            state_d = SEQ_LOCKED;
          end
        end else if (phy_err || tmo) begin
          // An UNLOCK that fails is not retried.
          if (cmd_q == CMD_UNLOCK) state_d = SEQ_FAIL;
          else                     fail_path = 1'b1;
        end
      end

      SEQ_LOCKED: begin
        if (stop_i) begin
          cmd_d   = CMD_UNLOCK;
          state_d = SEQ_ISSUE;
        end else if (phy_err) begin
`ifdef TUNER_SEQ_AUTO_RELOCK_EN
          fail_path = 1'b1;
`else
          state_d = SEQ_FAIL;
`endif
        end
      end

      SEQ_FAIL: begin
        if (start_i) begin
          retry_d = '0;
          cmd_d   = CMD_INIT;
          state_d = SEQ_ISSUE;
        end else if (stop_i) begin
          cmd_d   = CMD_UNLOCK;
          state_d = SEQ_ISSUE;
        end
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase

    // Shared failure handling: a pending stop turns the failure into
    // an UNLOCK, otherwise re-run bring-up while retries remain.
    if (fail_path) begin
      if (pend) begin
        cmd_d   = CMD_UNLOCK;
        state_d = SEQ_ISSUE;
      end else if (retry_q < RMAX) begin
        retry_d = retry_q + 4'd1;
        cmd_d   = CMD_INIT;
        state_d = SEQ_ISSUE;
      end else begin
        state_d = SEQ_FAIL;
      end
    end

    if (state_d == SEQ_LOCKED) retry_d = '0;

    if (state_d == SEQ_IDLE || state_d == SEQ_FAIL)
      pend_d = 1'b0;
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = valid_q;
  assign locked_o    = locked_q;
  assign error_o     = error_q;
  assign busy_o      = busy_q;
  assign retry_cnt_o = retry_q;
  assign seq_state_o = state_q;

endmodule

// File: tb/tb_tuner_cmd_seq.sv
// tb_tuner_cmd_seq: directed and randomized bring-up scenarios for
// tuner_cmd_seq with TIMEOUT_CYCLES=16 and MAX_RETRY=3.

module tb_tuner_cmd_seq;
  import tuner_pkg::*;

  localparam int TMO  = 16;
  localparam int MAXR = 3;

  localparam int S_IDLE   = 0;
  localparam int S_ISSUE  = 1;
  localparam int S_WAIT   = 2;
  localparam int S_LOCKED = 3;
  localparam int S_FAIL   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         stop_i;
  tuner_cmd_e   cmd_o;
  logic         cmd_valid_o;
  logic         cmd_ready_i;
  tuner_state_e state_i;
  logic         locked_o;
  logic         error_o;
  logic         busy_o;
  logic [3:0]   retry_cnt_o;
  logic [2:0]   seq_state_o;

  int tests = 0;
  int fails = 0;

  tuner_cmd_seq #(
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .stop_i(stop_i),
    .cmd_o(cmd_o),
    .cmd_valid_o(cmd_valid_o),
    .cmd_ready_i(cmd_ready_i),
    .state_i(state_i),
    .locked_o(locked_o),
    .error_o(error_o),
    .busy_o(busy_o),
    .retry_cnt_o(retry_cnt_o),
    .seq_state_o(seq_state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Command must be presented; stall it, then complete the handshake.
  task automatic issue(tuner_cmd_e exp, int stall, string tag);
    chk({tag, "_valid"}, 32'(cmd_valid_o), 1);
    chk({tag, "_cmd"}, 32'(cmd_o), 32'(exp));
    for (int i = 0; i < stall; i++) begin
      cmd_ready_i = 1'b0;
      step();
      chk({tag, "_hold"}, 32'(cmd_o), 32'(exp));
    end
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    chk({tag, "_hs_valid"}, 32'(cmd_valid_o), 0);
    chk({tag, "_hs_wait"}, 32'(seq_state_o), S_WAIT);
  endtask

  // PHY: ACTIVE right after handshake, DONE sampled lat cycles after it.
  task automatic respond(int lat, bit keep_done);
    for (int j = 1; j < lat; j++) begin
      state_i = PHY_ACTIVE;
      step();
      chk("wait_busy", 32'(busy_o), 1);
    end
    state_i = PHY_DONE;
    step();
    if (!keep_done) state_i = PHY_IDLE;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic bring_up(string tag);
    tuner_cmd_e seq_q[$];
    int lat;
    seq_q = '{CMD_INIT, CMD_SEARCH, CMD_LOCK};
    foreach (seq_q[k]) begin
      issue(seq_q[k], $urandom_range(0, 4), tag);
      lat = (k == 2) ? TMO : $urandom_range(2, TMO - 1);
      respond(lat, 1'b0);
    end
    chk({tag, "_locked"}, 32'(locked_o), 1);
    chk({tag, "_retry0"}, 32'(retry_cnt_o), 0);
    chk({tag, "_seq"}, 32'(seq_state_o), S_LOCKED);
    chk({tag, "_busy"}, 32'(busy_o), 0);
  endtask

  task automatic unlock_to_idle(string tag);
    issue(CMD_UNLOCK, $urandom_range(0, 3), tag);
    respond($urandom_range(2, 8), 1'b0);
    chk({tag, "_idle"}, 32'(seq_state_o), S_IDLE);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_locked"}, 32'(locked_o), 0);
  endtask

  initial begin
    int nfail;
    int d;
    rst         = 1'b1;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    cmd_ready_i = 1'b0;
    state_i     = PHY_IDLE;
    repeat (3) step();

    chk("rst_cmd", 32'(cmd_o), 32'(CMD_INIT));
    chk("rst_valid", 32'(cmd_valid_o), 0);
    chk("rst_locked", 32'(locked_o), 0);
    chk("rst_error", 32'(error_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_retry", 32'(retry_cnt_o), 0);
    chk("rst_seq", 32'(seq_state_o), S_IDLE);
    rst = 1'b0;
    step();

    // Nominal bring-up; stop alongside start in IDLE is ignored.
    start_i = 1'b1;
    stop_i  = 1'b1;
    step();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("start_seq", 32'(seq_state_o), S_ISSUE);
    chk("start_busy", 32'(busy_o), 1);
    bring_up("nom");

    // Stop from LOCKED.
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("stop_locked_drop", 32'(locked_o), 0);
    unlock_to_idle("stop");

    // Stale DONE held across the LOCK handshake.
    pulse_start();
    issue(CMD_INIT, 0, "stl_i");
    respond(5, 1'b0);
    issue(CMD_SEARCH, 1, "stl_s");
    respond(5, 1'b1);
    issue(CMD_LOCK, 2, "stl_l");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_ignored", 32'(seq_state_o), S_WAIT);
    end
    state_i = PHY_ACTIVE;
    step();
    chk("stale_not_yet", 32'(locked_o), 0);
    state_i = PHY_DONE;
    step();
    state_i = PHY_IDLE;
    chk("stale_locked", 32'(locked_o), 1);

    // Lock loss.
    state_i = PHY_ERROR;
    step();
    state_i = PHY_IDLE;
    chk("loss_locked", 32'(locked_o), 0);
`ifdef TUNER_SEQ_AUTO_RELOCK_EN
    chk("loss_retry", 32'(retry_cnt_o), 1);
    chk("loss_err", 32'(error_o), 0);
    bring_up("relock");
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    unlock_to_idle("loss");
`else
    chk("loss_err", 32'(error_o), 1);
    chk("loss_seq", 32'(seq_state_o), S_FAIL);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("fail_stop_err", 32'(error_o), 0);
    unlock_to_idle("loss");
`endif

    // Timeout on SEARCH, then random failures until retries run out.
    pulse_start();
    issue(CMD_INIT, 0, "tmo_i");
    respond(4, 1'b0);
    issue(CMD_SEARCH, 0, "tmo_s");
    for (int i = 1; i < TMO; i++) begin
      step();
      chk("tmo_quiet", 32'(cmd_valid_o), 0);
    end
    step();
    chk("tmo_reissue", 32'(cmd_o), 32'(CMD_INIT));
    chk("tmo_retry1", 32'(retry_cnt_o), 1);
    nfail = 1;
    while (nfail <= MAXR) begin
      issue(CMD_INIT, $urandom_range(0, 3), "rty");
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom_range(1, TMO - 1);
        for (int j = 1; j < d; j++) begin
          state_i = ($urandom_range(0, 1) == 1) ?
                    PHY_ACTIVE : PHY_IDLE;
          step();
        end
        state_i = PHY_ERROR;
        step();
        state_i = PHY_IDLE;
      end else begin
        repeat (TMO) step();
      end
      nfail++;
      if (nfail <= MAXR) begin
        chk("rty_valid", 32'(cmd_valid_o), 1);
        chk("rty_cnt", 32'(retry_cnt_o), 32'(nfail));
      end
    end
    chk("exh_err", 32'(error_o), 1);
    chk("exh_retry", 32'(retry_cnt_o), MAXR);
    chk("exh_seq", 32'(seq_state_o), S_FAIL);
    chk("exh_busy", 32'(busy_o), 0);

    // Restart from FAIL, backpressure with stop mid-stall.
    pulse_start();
    chk("rs_err", 32'(error_o), 0);
    chk("rs_retry", 32'(retry_cnt_o), 0);
    for (int i = 0; i < 10; i++) begin
      stop_i  = (i == 5);
      start_i = (i == 7);
      step();
      chk("bp_cmd", 32'(cmd_o), 32'(CMD_INIT));
      chk("bp_valid", 32'(cmd_valid_o), 1);
    end
    stop_i  = 1'b0;
    start_i = 1'b0;
    issue(CMD_INIT, 0, "bp_hs");
    respond($urandom_range(2, TMO - 1), 1'b0);
    chk("bp_unlock", 32'(cmd_o), 32'(CMD_UNLOCK));
    unlock_to_idle("bp");

    // Async reset in WAIT with a stop pending.
    pulse_start();
    issue(CMD_INIT, 0, "ar");
    state_i = PHY_ACTIVE;
    stop_i  = 1'b1;
    step();
    stop_i = 1'b0;
    step();
    #2 rst = 1'b1;
    state_i = PHY_IDLE;
    #1;
    chk("ar_cmd", 32'(cmd_o), 32'(CMD_INIT));
    chk("ar_valid", 32'(cmd_valid_o), 0);
    chk("ar_busy", 32'(busy_o), 0);
    chk("ar_seq", 32'(seq_state_o), S_IDLE);
    chk("ar_retry", 32'(retry_cnt_o), 0);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    issue(CMD_INIT, 0, "ar2");
    respond(4, 1'b0);
    chk("ar_no_pend", 32'(cmd_o), 32'(CMD_SEARCH));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
